regfile32: RTL and testbench

- 32-entry x 32-bit general-purpose register file for the cpu32 datapath.
- Storage is built on the positive-edge D-FF primitive, one enabled word register per entry.
- Sits directly downstream of that primitive.
- Feeds the ALU operand stage through two read ports and accepts one writeback port from the result stage.

---
 rtl/cpu32_pkg.sv | 10 +
 rtl/regfile32_if.sv | 27 ++
 rtl/regfile32_reg_word.sv | 21 ++
 rtl/regfile32.sv | 57 +++++
 tb/tb_regfile32.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/cpu32_pkg.sv
// Shared cpu32 datapath constants and types used by the register file.
package cpu32_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned REG_ZERO   = 0;

  typedef logic [ADDR_W_DEF-1:0] rf_addr_t;

endpackage

// File: rtl/regfile32_if.sv
// Register-file access bundle: one writeback port and two combinational read ports.
interface regfile32_if
  import cpu32_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
);

  logic              WE;
  logic [ADDR_W-1:0] WADDR;
  logic [DATA_W-1:0] WDATA;
  logic [ADDR_W-1:0] RADDR1;
  logic [DATA_W-1:0] RDATA1;
  logic [ADDR_W-1:0] RADDR2;
  logic [DATA_W-1:0] RDATA2;

  modport master (
    output WE, WADDR, WDATA, RADDR1, RADDR2,
    input  RDATA1, RDATA2
  );

  modport slave (
    input  WE, WADDR, WDATA, RADDR1, RADDR2,
    output RDATA1, RDATA2
  );

endinterface

// File: rtl/regfile32_reg_word.sv
// One enabled DATA_W-bit word on rising-edge D-FFs with synchronous active-low clear.
module reg_word #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic [DATA_W-1:0] D,
  output logic [DATA_W-1:0] Q
);

  // Clear wins over a write presented in the same cycle.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      Q <= '0;
    end else if (EN) begin
      Q <= D;
    end
  end

endmodule

// File: rtl/regfile32.sv
// 32x32 cpu32 register file: r0 hardwired to zero, two combinational read ports,
// one writeback port, optional same-cycle write-to-read forwarding.
module regfile32
  import cpu32_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter bit          BYPASS = 1'b1
) (
  input logic        CLK,
  input logic        RST,
  regfile32_if.slave bus
);

  localparam int unsigned       DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] word_q [DEPTH];
  logic              wr_ok_c;
  logic              fwd_ok_c;
  logic [DATA_W-1:0] rdata1_c;
  logic [DATA_W-1:0] rdata2_c;

  assign wr_ok_c  = bus.WE && (bus.WADDR != ZERO_ADDR);
  // Forwarding only for a write that will actually land at the next edge.
  assign fwd_ok_c = BYPASS && wr_ok_c && RST;

  assign word_q[0] = '0;

  generate
    for (genvar i = 1; i < DEPTH; i++) begin : g_word
      reg_word #(.DATA_W(DATA_W)) u_word (
        .CLK (CLK),
        .RST (RST),
        .EN  (wr_ok_c && (bus.WADDR == ADDR_W'(i))),
        .D   (bus.WDATA),
        .Q   (word_q[i])
      );
    end
  endgenerate

  // Read muxes; fwd_ok_c already excludes r0 so it always reads zero.
  always_comb begin
    rdata1_c = word_q[bus.RADDR1];
    rdata2_c = word_q[bus.RADDR2];
    if (fwd_ok_c && (bus.WADDR == bus.RADDR1)) begin
      rdata1_c = bus.WDATA;
    end
    if (fwd_ok_c && (bus.WADDR == bus.RADDR2)) begin
      rdata2_c = bus.WDATA;
    end
  end

  assign bus.RDATA1 = rdata1_c;
  assign bus.RDATA2 = rdata2_c;

endmodule

// File: tb/tb_regfile32.sv
// Self-checking bench for regfile32: directed vector table plus random traffic
// compared against an array-based model, with BYPASS=1 and BYPASS=0 instances.
module tb_regfile32;
  import cpu32_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  regfile32_if #(.DATA_W(32), .ADDR_W(5)) bus_b  ();
  regfile32_if #(.DATA_W(32), .ADDR_W(5)) bus_nb ();

  assign bus_nb.WE     = bus_b.WE;
  assign bus_nb.WADDR  = bus_b.WADDR;
  assign bus_nb.WDATA  = bus_b.WDATA;
  assign bus_nb.RADDR1 = bus_b.RADDR1;
  assign bus_nb.RADDR2 = bus_b.RADDR2;

  regfile32 #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) u_dut_b (
    .CLK (CLK), .RST (RST), .bus (bus_b)
  );
  regfile32 #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) u_dut_nb (
    .CLK (CLK), .RST (RST), .bus (bus_nb)
  );

  // Reference model: plain array of register contents.
  logic [31:0] mem [32];

  typedef struct {
    logic        rst;
    logic        we;
    rf_addr_t    waddr;
    logic [31:0] wdata;
    rf_addr_t    ra1;
    rf_addr_t    ra2;
    logic [31:0] e1_b;
    logic [31:0] e2_b;
    logic [31:0] e1_nb;
    logic [31:0] e2_nb;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input bit byp, input rf_addr_t a);
    if (a == 5'd0) return 32'h0;
    if (byp && RST && bus_b.WE && bus_b.WADDR == a) return bus_b.WDATA;
    return mem[a];
  endfunction

  task automatic drive(input logic rst, input logic we, input rf_addr_t wa,
                       input logic [31:0] wd, input rf_addr_t r1, input rf_addr_t r2);
    RST          = rst;
    bus_b.WE     = we;
    bus_b.WADDR  = wa;
    bus_b.WDATA  = wd;
    bus_b.RADDR1 = r1;
    bus_b.RADDR2 = r2;
  endtask

  // Advance one edge and update the model with what the DUT sampled.
  task automatic tick();
    @(posedge CLK);
    if (!RST) begin
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    end else if (bus_b.WE && bus_b.WADDR != 5'd0) begin
      mem[bus_b.WADDR] = bus_b.WDATA;
    end
    #1;
  endtask

  function automatic vec_t mk(input logic rst, input logic we, input rf_addr_t wa,
                              input logic [31:0] wd, input rf_addr_t r1, input rf_addr_t r2,
                              input logic [31:0] e1b, input logic [31:0] e2b,
                              input logic [31:0] e1n, input logic [31:0] e2n);
    vec_t v;
    v.rst = rst; v.we = we; v.waddr = wa; v.wdata = wd; v.ra1 = r1; v.ra2 = r2;
    v.e1_b = e1b; v.e2_b = e2b; v.e1_nb = e1n; v.e2_nb = e2n;
    return v;
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

    vecs[0]  = mk(0, 0, 5'd0, 32'h0,        5'd5,  5'd31, 32'h0, 32'h0, 32'h0, 32'h0);
    vecs[1]  = mk(1, 1, 5'd5, 32'hDEADBEEF, 5'd5,  5'd31, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0);
    vecs[2]  = mk(0, 0, 5'd0, 32'h0,        5'd5,  5'd31, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0);
    vecs[3]  = mk(1, 1, 5'd3, 32'h12345678, 5'd5,  5'd3,  32'h0, 32'h12345678, 32'h0, 32'h0);
    vecs[4]  = mk(1, 0, 5'd3, 32'h0,        5'd3,  5'd4,  32'h12345678, 32'h0, 32'h12345678, 32'h0);
    vecs[5]  = mk(1, 1, 5'd0, 32'hFFFFFFFF, 5'd0,  5'd0,  32'h0, 32'h0, 32'h0, 32'h0);
    vecs[6]  = mk(1, 0, 5'd0, 32'hFFFFFFFF, 5'd0,  5'd0,  32'h0, 32'h0, 32'h0, 32'h0);
    vecs[7]  = mk(1, 1, 5'd7, 32'h00000011, 5'd7,  5'd7,  32'h11, 32'h11, 32'h0, 32'h0);
    vecs[8]  = mk(1, 1, 5'd7, 32'h00000022, 5'd7,  5'd7,  32'h22, 32'h22, 32'h11, 32'h11);
    vecs[9]  = mk(1, 0, 5'd7, 32'h0,        5'd7,  5'd7,  32'h22, 32'h22, 32'h22, 32'h22);
    vecs[10] = mk(0, 1, 5'd9, 32'hA5A5A5A5, 5'd9,  5'd7,  32'h0, 32'h22, 32'h0, 32'h22);
    vecs[11] = mk(1, 0, 5'd9, 32'h0,        5'd9,  5'd7,  32'h0, 32'h0, 32'h0, 32'h0);
    vecs[12] = mk(1, 1, 5'd3, 32'h12345678, 5'd3,  5'd3,  32'h12345678, 32'h12345678, 32'h0, 32'h0);
    vecs[13] = mk(1, 0, 5'd1, 32'h00000001, 5'd3,  5'd1,  32'h12345678, 32'h0, 32'h12345678, 32'h0);
    vecs[14] = mk(1, 0, 5'd2, 32'h00000002, 5'd3,  5'd2,  32'h12345678, 32'h0, 32'h12345678, 32'h0);
    vecs[15] = mk(1, 0, 5'd1, 32'h00000001, 5'd3,  5'd2,  32'h12345678, 32'h0, 32'h12345678, 32'h0);

    @(posedge CLK); #1;

    for (int k = 0; k < 16; k++) begin
      drive(vecs[k].rst, vecs[k].we, vecs[k].waddr, vecs[k].wdata, vecs[k].ra1, vecs[k].ra2);
      #3;
      chk($sformatf("vec%0d_b_rd1", k),  bus_b.RDATA1,  vecs[k].e1_b);
      chk($sformatf("vec%0d_b_rd2", k),  bus_b.RDATA2,  vecs[k].e2_b);
      chk($sformatf("vec%0d_nb_rd1", k), bus_nb.RDATA1, vecs[k].e1_nb);
      chk($sformatf("vec%0d_nb_rd2", k), bus_nb.RDATA2, vecs[k].e2_nb);
      tick();
    end

    // Mid-cycle toggling of WE/WADDR/WDATA must not disturb stored state.
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b0, 5'd3, 32'h1, 5'd3, 5'd5);
      #1 bus_b.WE = 1'b1; bus_b.WDATA = 32'h2;
      #1 bus_b.WADDR = 5'd5;
      #1 bus_b.WE = 1'b0; bus_b.WDATA = 32'h1;
      #1 bus_b.WADDR = 5'd3;
      tick();
      chk($sformatf("hold%0d_r3", c), bus_b.RDATA1, 32'h12345678);
      chk($sformatf("hold%0d_r5", c), bus_nb.RDATA2, 32'h0);
    end

    // Random traffic against the model.
    for (int n = 0; n < 500; n++) begin
      rf_addr_t wa, r1, r2;
      wa = rf_addr_t'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 2) == 0) ? wa : rf_addr_t'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 2) == 0) ? wa : rf_addr_t'($urandom_range(0, 31));
      drive(($urandom_range(0, 24) != 0), 1'($urandom_range(0, 1)), wa,
            32'($urandom), r1, r2);
      #3;
      chk($sformatf("rnd%0d_b_rd1", n),  bus_b.RDATA1,  model_rd(1'b1, r1));
      chk($sformatf("rnd%0d_b_rd2", n),  bus_b.RDATA2,  model_rd(1'b1, r2));
      chk($sformatf("rnd%0d_nb_rd1", n), bus_nb.RDATA1, model_rd(1'b0, r1));
      chk($sformatf("rnd%0d_nb_rd2", n), bus_nb.RDATA2, model_rd(1'b0, r2));
      tick();
    end

    // Full sweep of stored contents through both ports after the random run.
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    for (int a = 0; a < 32; a++) begin
      bus_b.RADDR1 = rf_addr_t'(a);
      bus_b.RADDR2 = rf_addr_t'(31 - a);
      #1;
      chk($sformatf("sweep%0d_rd1", a), bus_b.RDATA1,  model_rd(1'b1, rf_addr_t'(a)));
      chk($sformatf("sweep%0d_rd2", a), bus_nb.RDATA2, model_rd(1'b0, rf_addr_t'(31 - a)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
